// File: rtl/nes_pkg.sv
// Shared types and constants for the NES controller polling block.
package nes_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLatch,
        StShift,
        StDone
    } nes_state_e;

    // Bit positions within buttons1/buttons2 (serial order from the controller)
    localparam int unsigned BtnA      = 0;
    localparam int unsigned BtnB      = 1;
    localparam int unsigned BtnSelect = 2;
    localparam int unsigned BtnStart  = 3;
    localparam int unsigned BtnUp     = 4;
    localparam int unsigned BtnDown   = 5;
    localparam int unsigned BtnLeft   = 6;
    localparam int unsigned BtnRight  = 7;

    localparam int unsigned NumButtons = 8;

    localparam int unsigned DefaultClkDiv    = 4;
    localparam int unsigned DefaultPollTicks = 100;

endpackage

// File: rtl/nes_tick_gen.sv
// Protocol tick divider: one-cycle tick every CLK_DIV clocks, restartable via clear.
module nes_tick_gen
    import nes_pkg::*;
#(
    parameter int unsigned CLK_DIV = DefaultClkDiv
) (
    input  logic CLK,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CntW = $clog2(CLK_DIV);

    logic [CntW-1:0] r_cnt;

    assign tick = (r_cnt == CntW'(CLK_DIV - 1));

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (clear || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/nes_poll_ctrl.sv
// Polls two NES controllers (latch + 8 serial slots) on request or periodically,
// publishing both button bytes atomically with a one-cycle valid pulse.
module nes_poll_ctrl
    import nes_pkg::*;
#(
    parameter int unsigned CLK_DIV    = DefaultClkDiv,
    parameter int unsigned POLL_TICKS = DefaultPollTicks
) (
    input  logic       CLK,
    input  logic       reset_n,
    input  logic       en,
    input  logic       poll_req,
    input  logic       data1,
    input  logic       data2,
    output logic       nes_latch,
    output logic       nes_clk,
    output logic [7:0] buttons1,
    output logic [7:0] buttons2,
    output logic       valid,
    output logic       busy
);

    localparam int unsigned PerW = $clog2(POLL_TICKS);

    logic            r_data1_meta, r_data1_sync;
    logic            r_data2_meta, r_data2_sync;
    nes_state_e      r_state, w_state_next;
    logic            r_half, w_half_next;
    logic [2:0]      r_slot, w_slot_next;
    logic [PerW-1:0] r_period;
    logic            r_pending;
    logic [7:0]      r_shadow1, r_shadow2;
    logic [7:0]      w_shadow1_next, w_shadow2_next;
    logic [7:0]      r_buttons1, r_buttons2;
    logic            r_nes_latch, r_nes_clk;
    logic            w_nes_latch_next, w_nes_clk_next;
    logic            w_tick, w_start, w_sample, w_load, w_periodic;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_data1_meta <= 1'b1;
            r_data1_sync <= 1'b1;
            r_data2_meta <= 1'b1;
            r_data2_sync <= 1'b1;
        end else begin
            r_data1_meta <= data1;
            r_data1_sync <= r_data1_meta;
            r_data2_meta <= data2;
            r_data2_sync <= r_data2_meta;
        end
    end

    nes_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_gen (
        .CLK    (CLK),
        .reset_n(reset_n),
        .clear  (w_start),
        .tick   (w_tick)
    );

    assign w_periodic = en && w_tick && (r_period == PerW'(POLL_TICKS - 1));

    always_comb begin
        w_state_next = r_state;
        w_half_next  = r_half;
        w_slot_next  = r_slot;
        w_start      = 1'b0;
        w_sample     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (poll_req || r_pending || w_periodic) begin
                    w_start      = 1'b1;
                    w_state_next = StLatch;
                    w_half_next  = 1'b0;
                    w_slot_next  = 3'd0;
                end
            end
            StLatch: begin
                if (w_tick) begin
                    if (r_half) begin
                        w_state_next = StShift;
                        w_half_next  = 1'b0;
                        w_slot_next  = 3'd0;
                    end else begin
                        w_half_next = 1'b1;
                    end
                end
            end
            StShift: begin
                if (w_tick) begin
                    if (r_half) begin
                        w_sample    = 1'b1;
                        w_half_next = 1'b0;
                        if (r_slot == 3'(NumButtons - 1)) begin
                            w_state_next = StDone;
                        end else begin
                            w_slot_next = r_slot + 3'd1;
                        end
                    end else begin
                        w_half_next = 1'b1;
                    end
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // The final slot's sample is merged here so buttons update on the edge into
    // DONE, making new data visible in the same cycle as valid.
    always_comb begin
        w_shadow1_next = r_shadow1;
        w_shadow2_next = r_shadow2;
        if (w_sample) begin
            w_shadow1_next[r_slot] = ~r_data1_sync;
            w_shadow2_next[r_slot] = ~r_data2_sync;
        end
    end

    assign w_load = w_sample && (w_state_next == StDone);

    always_comb begin
        w_nes_latch_next = (w_state_next == StLatch);
        w_nes_clk_next   = (w_state_next == StShift) && (w_slot_next != 3'd0) && !w_half_next;
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
            r_half  <= 1'b0;
            r_slot  <= 3'd0;
        end else begin
            r_state <= w_state_next;
            r_half  <= w_half_next;
            r_slot  <= w_slot_next;
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_period <= '0;
        end else if (w_start || !en) begin
            r_period <= '0;
        end else if ((r_state == StIdle) && w_tick) begin
            r_period <= r_period + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= 1'b0;
        end else if (w_start) begin
            r_pending <= 1'b0;
        end else if (poll_req && (r_state != StIdle)) begin
            r_pending <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_shadow1   <= 8'h00;
            r_shadow2   <= 8'h00;
            r_buttons1  <= 8'h00;
            r_buttons2  <= 8'h00;
            r_nes_latch <= 1'b0;
            r_nes_clk   <= 1'b0;
        end else begin
            r_shadow1   <= w_shadow1_next;
            r_shadow2   <= w_shadow2_next;
            r_nes_latch <= w_nes_latch_next;
            r_nes_clk   <= w_nes_clk_next;
            if (w_load) begin
                r_buttons1 <= w_shadow1_next;
                r_buttons2 <= w_shadow2_next;
            end
        end
    end

    assign nes_latch = r_nes_latch;
    assign nes_clk   = r_nes_clk;
    assign buttons1  = r_buttons1;
    assign buttons2  = r_buttons2;
    assign valid     = (r_state == StDone);
    assign busy      = (r_state != StIdle);

endmodule

// File: tb/tb_nes_poll_ctrl.sv
// Directed bench for nes_poll_ctrl with a behavioural shift-register controller model.
module tb_nes_poll_ctrl;

    logic       CLK = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b0;
    logic       poll_req = 1'b0;
    logic       data1, data2;
    logic       nes_latch, nes_clk, valid, busy;
    logic [7:0] buttons1, buttons2;

    nes_poll_ctrl #(
        .CLK_DIV   (4),
        .POLL_TICKS(100)
    ) dut (
        .CLK      (CLK),
        .reset_n  (reset_n),
        .en       (en),
        .poll_req (poll_req),
        .data1    (data1),
        .data2    (data2),
        .nes_latch(nes_latch),
        .nes_clk  (nes_clk),
        .buttons1 (buttons1),
        .buttons2 (buttons2),
        .valid    (valid),
        .busy     (busy)
    );

    always #5 CLK = ~CLK;

    // Controller model: parallel load while latched, shift on nes_clk rising edge.
    logic [7:0] press1 = 8'h00, press2 = 8'h00;
    logic [7:0] sr1 = 8'h00, sr2 = 8'h00;
    logic       nclk_q = 1'b0;
    always @(posedge CLK) begin
        nclk_q <= nes_clk;
        if (nes_latch) begin
            sr1 <= press1;
            sr2 <= press2;
        end else if (nes_clk && !nclk_q) begin
            sr1 <= {1'b0, sr1[7:1]};
            sr2 <= {1'b0, sr2[7:1]};
        end
    end
    assign data1 = ~sr1[0];
    assign data2 = ~sr2[0];

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int   latch_cnt = 0, clk_hi_cnt = 0, clk_rise = 0, valid_cnt = 0, busy_cnt = 0;
    logic clk_prev = 1'b0;
    always @(negedge CLK) begin
        latch_cnt  <= latch_cnt + int'(nes_latch);
        clk_hi_cnt <= clk_hi_cnt + int'(nes_clk);
        clk_rise   <= clk_rise + int'(nes_clk && !clk_prev);
        clk_prev   <= nes_clk;
        valid_cnt  <= valid_cnt + int'(valid);
        busy_cnt   <= busy_cnt + int'(busy);
    end

    int n_pass = 0, n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic pulse_req(output int s);
        @(negedge CLK);
        poll_req = 1'b1;
        s = cyc;
        @(negedge CLK);
        poll_req = 1'b0;
    endtask

    task automatic wait_valid(input int bound, output int at);
        at = -1000000;
        for (int i = 0; i < bound; i++) begin
            @(negedge CLK);
            if (valid === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    int s, s2, v1, v2, v3, r, l0, c0, h0, b0, k0;

    initial begin
        // Reset state
        #1;
        check("rst_latch", nes_latch, 0);
        check("rst_nclk", nes_clk, 0);
        check("rst_btn1", buttons1, 8'h00);
        check("rst_btn2", buttons2, 8'h00);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        repeat (3) @(negedge CLK);
        reset_n = 1'b1;

        // Disabled and no requests: bus stays quiet
        l0 = latch_cnt; h0 = clk_hi_cnt; b0 = busy_cnt;
        repeat (2000) @(negedge CLK);
        check("idle_latch", latch_cnt - l0, 0);
        check("idle_nclk", clk_hi_cnt - h0, 0);
        check("idle_busy", busy_cnt - b0, 0);

        // Single requested poll, A+Start on controller 1
        press1 = 8'h09; press2 = 8'h00;
        l0 = latch_cnt; c0 = clk_rise;
        pulse_req(s);
        check("req_busy", busy, 1);
        check("req_latch", nes_latch, 1);
        wait_valid(200, v1);
        check("req_lat", v1 - s, 73);
        check("req_btn1", buttons1, 8'h09);
        check("req_btn2", buttons2, 8'h00);
        repeat (4) @(negedge CLK);
        check("req_latch_cyc", latch_cnt - l0, 8);
        check("req_nclk_pulses", clk_rise - c0, 7);

        // Two requests while busy collapse into one follow-up poll
        press1 = 8'hA5; press2 = 8'h3C;
        k0 = valid_cnt;
        pulse_req(s);
        repeat (5) @(negedge CLK);
        pulse_req(s2);
        repeat (20) @(negedge CLK);
        pulse_req(s2);
        wait_valid(200, v1);
        check("pend_lat", v1 - s, 73);
        check("pend_btn1", buttons1, 8'hA5);
        wait_valid(200, v2);
        check("pend_gap", v2 - v1, 74);
        check("pend_btn2", buttons2, 8'h3C);
        repeat (300) @(negedge CLK);
        check("pend_valid_cnt", valid_cnt - k0, 2);

        // en dropped during LATCH: poll completes, no automatic polls follow
        press1 = 8'h00; press2 = 8'h80;
        en = 1'b1;
        pulse_req(s);
        repeat (2) @(negedge CLK);
        en = 1'b0;
        check("endrop_latch", nes_latch, 1);
        wait_valid(200, v1);
        check("endrop_lat", v1 - s, 73);
        check("endrop_btn2", buttons2, 8'h80);
        check("endrop_btn1", buttons1, 8'h00);
        repeat (2) @(negedge CLK);
        l0 = latch_cnt;
        repeat (1000) @(negedge CLK);
        check("endrop_no_latch", latch_cnt - l0, 0);

        // Periodic polling, all buttons pressed on both controllers
        press1 = 8'hFF; press2 = 8'hFF;
        en = 1'b1;
        wait_valid(600, v1);
        check("per_btn1", buttons1, 8'hFF);
        check("per_btn2", buttons2, 8'hFF);
        wait_valid(600, v2);
        check("per_gap1", v2 - v1, 472);
        wait_valid(600, v3);
        check("per_gap2", v3 - v2, 472);
        check("per_btn1b", buttons1, 8'hFF);
        en = 1'b0;

        // Reset during SHIFT slot 4 abandons the poll
        @(negedge CLK);
        reset_n = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst2_btn1", buttons1, 8'h00);
        reset_n = 1'b1;
        pulse_req(s);
        repeat (42) @(negedge CLK);
        check("slot4_nclk", nes_clk, 1);
        k0 = valid_cnt;
        reset_n = 1'b0;
        #1;
        check("midrst_nclk", nes_clk, 0);
        check("midrst_latch", nes_latch, 0);
        check("midrst_busy", busy, 0);
        check("midrst_valid", valid, 0);
        check("midrst_btn1", buttons1, 8'h00);
        repeat (3) @(negedge CLK);
        en = 1'b1;
        reset_n = 1'b1;
        r = cyc;
        repeat (100) @(negedge CLK);
        check("midrst_no_valid", valid_cnt - k0, 0);
        check("midrst_btn_hold", buttons1, 8'h00);
        wait_valid(500, v1);
        check("postrst_first_poll", v1 - r, 472);
        check("postrst_btn1", buttons1, 8'hFF);
        en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
